// File: rtl/vga_ellipses_pkg.sv
// Shared constants for the VGA ellipse generator: default 640x480@60 timing,
// frame totals, ellipse geometry, RGB565 colours and the ellipse membership test.
package vga_ellipses_pkg;

    // Default horizontal timing in pixels
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_TOTAL_DEF  = H_SYNC_DEF + H_BACK_DEF + H_ACTIVE_DEF + H_FRONT_DEF;

    // Default vertical timing in lines
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_TOTAL_DEF  = V_SYNC_DEF + V_BACK_DEF + V_ACTIVE_DEF + V_FRONT_DEF;

    // Counter and coordinate width, wide enough for any sensible VGA mode
    localparam int CNT_W = 12;

    // Ellipse geometry in active-area pixel coordinates
    localparam int CENTRE_X = 320;
    localparam int CENTRE_Y = 240;
    localparam int INNER_A  = 100;
    localparam int INNER_B  = 75;
    localparam int OUTER_A  = 200;
    localparam int OUTER_B  = 150;

    // Width of the ellipse products; 48 bits leaves ample headroom
    localparam int PROD_W = 48;

    // RGB565 colours
    localparam logic [15:0] RGB_BLACK = 16'h0000;
    localparam logic [15:0] RGB_BLUE  = 16'h001F;
    localparam logic [15:0] RGB_RED   = 16'hF800;
    localparam logic [15:0] RGB_WHITE = 16'hFFFF;

    // True when (dx,dy) lies inside or on the ellipse with semi-axes a (x) and b (y):
    // dx^2*b^2 + dy^2*a^2 <= a^2*b^2, all unsigned.
    function automatic logic in_ellipse(input logic [CNT_W-1:0] dx,
                                        input logic [CNT_W-1:0] dy,
                                        input logic [15:0]      a,
                                        input logic [15:0]      b);
        logic [PROD_W-1:0] dx2;
        logic [PROD_W-1:0] dy2;
        logic [PROD_W-1:0] a2;
        logic [PROD_W-1:0] b2;
        logic [PROD_W-1:0] lhs;
        logic [PROD_W-1:0] rhs;
        dx2 = PROD_W'(dx) * PROD_W'(dx);
        dy2 = PROD_W'(dy) * PROD_W'(dy);
        a2  = PROD_W'(a) * PROD_W'(a);
        b2  = PROD_W'(b) * PROD_W'(b);
        lhs = (dx2 * b2) + (dy2 * a2);
        rhs = a2 * b2;
        return (lhs <= rhs);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// VGA raster timing: 25 MHz pixel enable from the 50 MHz clock, horizontal and
// vertical counters, active-low sync decode and active-area pixel coordinates.
module vga_timing
    import vga_ellipses_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             hsync_next,
    output logic             vsync_next,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y
);

    localparam int H_START = H_SYNC + H_BACK;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int H_TOTAL = H_END + H_FRONT;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_ACTIVE;
    localparam int V_TOTAL = V_END + V_FRONT;

    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_END);
    localparam logic [CNT_W-1:0] H_LAST_C  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_END);
    localparam logic [CNT_W-1:0] V_LAST_C  = CNT_W'(V_TOTAL - 1);

    logic             pix_en;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_active;
    logic             v_active;

    // Pixel enable toggles every clock; counters step only when it is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (h_cnt == H_LAST_C) begin
                    h_cnt <= '0;
                    if (v_cnt == V_LAST_C) begin
                        v_cnt <= '0;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // Sync levels, active window and pixel coordinates from the current counts
    always_comb begin
        hsync_next = (h_cnt < H_SYNC_C) ? 1'b0 : 1'b1;
        vsync_next = (v_cnt < V_SYNC_C) ? 1'b0 : 1'b1;
        h_active   = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
        v_active   = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
        active     = h_active && v_active;
        x          = '0;
        y          = '0;
        if (active) begin
            x = h_cnt - H_START_C;
            y = v_cnt - V_START_C;
        end
    end

endmodule

// File: rtl/vga_ellipses.sv
// VGA test pattern: blue inner ellipse over a red outer ellipse on a white
// background, black outside the visible area. Sync and colour are registered
// together so all outputs share one clock of latency.
module vga_ellipses
    import vga_ellipses_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb
);

    localparam logic [CNT_W-1:0] CX = CNT_W'(CENTRE_X);
    localparam logic [CNT_W-1:0] CY = CNT_W'(CENTRE_Y);

    logic             hsync_next;
    logic             vsync_next;
    logic             active;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] dx;
    logic [CNT_W-1:0] dy;
    logic             in_inner;
    logic             in_outer;
    logic [15:0]      colour;

    vga_timing #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .hsync_next (hsync_next),
        .vsync_next (vsync_next),
        .active     (active),
        .x          (x),
        .y          (y)
    );

    // Distance from the centre and ellipse membership; inner ellipse wins
    always_comb begin
        dx       = (x >= CX) ? (x - CX) : (CX - x);
        dy       = (y >= CY) ? (y - CY) : (CY - y);
        in_inner = in_ellipse(dx, dy, 16'(INNER_A), 16'(INNER_B));
        in_outer = in_ellipse(dx, dy, 16'(OUTER_A), 16'(OUTER_B));
        colour   = RGB_BLACK;
        if (active) begin
            if (in_inner) begin
                colour = RGB_BLUE;
            end else if (in_outer) begin
                colour = RGB_RED;
            end else begin
                colour = RGB_WHITE;
            end
        end
    end

    // Output registers: syncs idle high and colour black while in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= RGB_BLACK;
        end else begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            rgb   <= colour;
        end
    end

endmodule

// File: tb/tb_vga_ellipses.sv
// Testbench for vga_ellipses: sync timing measurements, directed pixel checks on
// selected lines (vertical count pinned to reach deep lines quickly) and random
// sampling against a raster/ellipse reference model.
module tb_vga_ellipses;
    import vga_ellipses_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = -1;      // clock edges since reset release (0 = first edge)
    bit model_ok = 1'b0;
    bit forced   = 1'b0;
    int fv       = 0;
    logic [CNT_W-1:0] fv_vec = '0;

    int          tgt_h[$];
    logic [15:0] tgt_rgb[$];

    always #10 clk = ~clk;

    vga_ellipses dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hsync (hsync),
        .vsync (vsync),
        .rgb   (rgb)
    );

    // Reference model: one pixel per two clocks, 800 pixels/line, 525 lines/frame
    function automatic int cur_h();
        return (n / 2) % 800;
    endfunction

    function automatic int cur_v();
        if (forced) return fv;
        return ((n / 2) / 800) % 525;
    endfunction

    function automatic bit m_inside(longint dx, longint dy, longint a, longint b);
        return (dx * dx * b * b + dy * dy * a * a) <= (a * a * b * b);
    endfunction

    function automatic logic [15:0] exp_rgb(int h, int v);
        longint px, py, dx, dy;
        if (h < 144 || h > 783 || v < 35 || v > 514) return 16'h0000;
        px = h - 144;
        py = v - 35;
        dx = (px > 320) ? px - 320 : 320 - px;
        dy = (py > 240) ? py - 240 : 240 - py;
        if (m_inside(dx, dy, 100, 75))  return 16'h001F;
        if (m_inside(dx, dy, 200, 150)) return 16'hF800;
        return 16'hFFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample_model();
        int h, v;
        h = cur_h();
        v = cur_v();
        check($sformatf("rnd_hsync h%0d v%0d", h, v), 32'(hsync), (h < 96) ? 32'd0 : 32'd1);
        check($sformatf("rnd_vsync h%0d v%0d", h, v), 32'(vsync), (v < 2) ? 32'd0 : 32'd1);
        check($sformatf("rnd_rgb h%0d v%0d", h, v), 32'(rgb), 32'(exp_rgb(h, v)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (model_ok && $urandom_range(0, 31) == 0) sample_model();
    endtask

    task automatic measure_hsync(input string tag);
        int lo, per;
        lo = 0;
        while (hsync === 1'b0 && lo < 4000) begin
            lo++;
            tick();
        end
        check({tag, "_hsync_low"}, 32'(lo), 32'd192);
        per = lo;
        while (hsync === 1'b1 && per < 4000) begin
            per++;
            tick();
        end
        check({tag, "_hsync_period"}, 32'(per), 32'd1600);
    endtask

    task automatic scan(input int v);
        fv_vec = CNT_W'(v);
        fv     = v;
        forced = 1'b1;
        for (int i = 0; i < 1602; i++) begin
            tick();
            for (int k = 0; k < tgt_h.size(); k++) begin
                if (cur_h() == tgt_h[k])
                    check($sformatf("pix_h%0d_v%0d", tgt_h[k], v), 32'(rgb), 32'(tgt_rgb[k]));
            end
        end
    endtask

    initial begin
        int g;
        // Reset state
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_rgb", 32'(rgb), 32'd0);

        // Release: syncs drop on the first edge
        rst_n    = 1'b1;
        n        = -1;
        model_ok = 1'b1;
        tick();
        check("first_hsync", 32'(hsync), 32'd0);
        check("first_vsync", 32'(vsync), 32'd0);
        check("first_rgb", 32'(rgb), 32'd0);

        measure_hsync("init");

        g = 0;
        while (vsync === 1'b0 && g < 4000) begin
            tick();
            g++;
        end
        check("vsync_low", 32'(n), 32'd3200);

        // Pin the vertical count to visit selected lines
        fv_vec = CNT_W'(275);
        force dut.u_timing.v_cnt = fv_vec;

        tgt_h   = '{143, 144, 464, 614, 664, 665, 783, 784};
        tgt_rgb = '{16'h0000, 16'hFFFF, 16'h001F, 16'hF800, 16'hF800, 16'hFFFF, 16'hFFFF, 16'h0000};
        scan(275);     // y = 240

        tgt_h   = '{464};
        tgt_rgb = '{16'hF800};
        scan(125);     // y = 90, dy = 150 boundary

        tgt_rgb = '{16'hFFFF};
        scan(124);     // y = 89

        tgt_rgb = '{16'h0000};
        scan(34);      // line above active area

        tgt_h   = '{144, 790};
        tgt_rgb = '{16'hFFFF, 16'h0000};
        scan(35);      // y = 0

        tgt_h   = '{783, 790};
        tgt_rgb = '{16'hFFFF, 16'h0000};
        scan(514);     // y = 479

        tgt_h   = '{10, 100, 790};
        tgt_rgb = '{16'h0000, 16'h0000, 16'h0000};
        scan(520);     // bottom blanking

        release dut.u_timing.v_cnt;
        forced   = 1'b0;
        model_ok = 1'b0;

        // Mid-line reset for 3 clocks
        repeat (37) tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_hsync_%0d", i), 32'(hsync), 32'd1);
            check($sformatf("midrst_vsync_%0d", i), 32'(vsync), 32'd1);
            check($sformatf("midrst_rgb_%0d", i), 32'(rgb), 32'd0);
        end
        rst_n    = 1'b1;
        n        = -1;
        model_ok = 1'b1;
        tick();
        check("rel_hsync", 32'(hsync), 32'd0);
        check("rel_vsync", 32'(vsync), 32'd0);
        measure_hsync("rel");
        repeat (400) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_ellipses.md
VGA_ELLIPSES -- requirements
Module: vga_ellipses

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-002 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-003 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-004 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-005 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-006 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-007 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-008 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-009 SHALL have port clk, input, 1 bit: the single 50 MHz system clock; all logic is on its rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-011 SHALL have port hsync, output, 1 bit: horizontal sync, active-low.
REQ-012 SHALL have port vsync, output, 1 bit: vertical sync, active-low.
REQ-013 SHALL have port rgb, output, 16 bits: pixel colour in RGB565 format.

Function
REQ-014 SHALL generate an internal pixel enable pix_en that toggles every clk, giving 25 MHz; pix_en is 0 on the first cycle after reset release.
REQ-015 SHALL advance h_cnt (0..H_TOTAL-1, H_TOTAL=800) on cycles with pix_en=1, wrapping to 0 after 799.
REQ-016 SHALL advance v_cnt (0..V_TOTAL-1, V_TOTAL=525) when h_cnt wraps, wrapping to 0 after 524.
REQ-017 Sync region is h_cnt<H_SYNC and v_cnt<V_SYNC; hsync and vsync SHALL be 0 there and 1 elsewhere.
REQ-018 Active region: h_cnt in [144,783], v_cnt in [35,514]; pixel x=h_cnt-144, y=v_cnt-35.
REQ-019 SHALL register hsync, vsync and rgb every clk from current counter values, so all three are aligned with the same one-cycle latency.
REQ-020 Outside the active region, rgb SHALL be 16'h0000.
REQ-021 Inside the active region, with dx=|x-320| and dy=|y-240|, pixel SHALL be in ellipse(A,B) iff dx²·B² + dy²·A² <= A²·B²; the boundary counts as inside.
REQ-022 In inner ellipse (A=100, B=75): rgb=16'h001F (blue), highest priority.
REQ-023 Otherwise in outer ellipse (A=200, B=150): rgb=16'hF800 (red).
REQ-024 Otherwise rgb=16'hFFFF (white background).
REQ-025 Ellipse arithmetic SHALL be unsigned with products at least 40 bits wide, so no overflow occurs.

Reset
REQ-026 While rst_n=0 at a clk edge: h_cnt=0, v_cnt=0, pix_en=0, hsync=1, vsync=1, rgb=16'h0000.
REQ-027 Reset asserted mid-frame SHALL restart timing from h_cnt=0, v_cnt=0 on release.
REQ-028 On the first clk after release, hsync and vsync SHALL go to 0, since the counters are in the sync region.

Structure
REQ-029 Package vga_ellipses_pkg SHALL hold the timing constants, the totals, the ellipse centre and axes, and the colour constants.
REQ-030 Sub-module vga_timing SHALL contain pix_en, the counters, the sync decode and the active/x/y outputs; the top SHALL add the ellipse colour logic and output registers.

Verification
REQ-031 Release reset and measure hsync: low 192 clk, period 1600 clk.
REQ-032 Measure vsync: low 3200 clk, period 840000 clk.
REQ-033 Pixel (320,240) -> rgb=16'h001F; pixel (470,240) -> 16'hF800; pixel (520,240), boundary -> 16'hF800; pixel (521,240) -> 16'hFFFF.
REQ-034 Pixel (0,0) and pixel (639,479) -> 16'hFFFF; h_cnt=790 on any line -> rgb=16'h0000.
REQ-035 Pixel (320,90), dy=150 boundary -> 16'hF800; pixel (320,89) -> 16'hFFFF.
REQ-036 Assert rst_n=0 mid-line for 3 clk -> outputs hsync=1, vsync=1, rgb=0; after release, hsync and vsync go low on the next clk and the hsync period resumes at 1600 clk.
